// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - opcode type and board limits shared by the io command path
package io_pkg;

  typedef enum logic [1:0] {
    IO_OP_LED  = 2'd0,
    IO_OP_SEG  = 2'd1,
    IO_OP_READ = 2'd2,
    IO_OP_RSVD = 2'd3
  } io_op_t;

  localparam int IO_MAX_SWITCH_IDX = 13;
  localparam int IO_NUM_LED        = 18;
  localparam int IO_NUM_DIGIT      = 4;

  function automatic logic read_ok(io_op_t op, logic [31:0] idx);
    return (op == IO_OP_READ) && (idx <= 32'(IO_MAX_SWITCH_IDX));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at rr_ptr
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    int   idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/io_arbiter.sv
// rtl/io_arbiter.sv - shares the io command port between requesters, returns tagged switch reads
module io_arbiter
  import io_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [2*NUM_REQ-1:0]  req_op,
  input  logic [32*NUM_REQ-1:0] req_control,
  input  logic [32*NUM_REQ-1:0] req_value,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_data,
  output logic                  rsp_err,
  output logic                  LightLED,
  output logic                  LightSevenSegment,
  output logic                  ReadSwitch,
  output logic [31:0]           control,
  output logic [31:0]           value,
  input  logic                  SwitchValue
);

  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} state_t;

  state_t             state, state_next;
  logic [ID_W-1:0]    rr_ptr, grant_idx;
  logic [NUM_REQ-1:0] grant;
  io_op_t             op_q, sel_op;
  logic [31:0]        sel_control, sel_value;
  logic               take, sel_bad;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Gating with reset_n keeps a held reset from looking like a handshake.
  assign req_ready = (state == IDLE && reset_n) ? grant : '0;
  assign take      = |req_ready;

  always_comb begin
    sel_op      = IO_OP_LED;
    sel_control = '0;
    sel_value   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_op      = io_op_t'(req_op[2*i +: 2]);
        sel_control = req_control[32*i +: 32];
        sel_value   = req_value[32*i +: 32];
      end
    end
    sel_bad = (sel_op == IO_OP_RSVD) || (sel_op == IO_OP_READ && !read_ok(sel_op, sel_value));
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (take) state_next = ISSUE;
      ISSUE:   state_next = read_ok(op_q, value) ? RDWAIT : IDLE;
      RDWAIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr            <= '0;
      op_q              <= IO_OP_LED;
      control           <= '0;
      value             <= '0;
      rsp_id            <= '0;
      rsp_valid         <= 1'b0;
      rsp_err           <= 1'b0;
      LightLED          <= 1'b0;
      LightSevenSegment <= 1'b0;
      ReadSwitch        <= 1'b0;
    end else begin
      LightLED          <= 1'b0;
      LightSevenSegment <= 1'b0;
      ReadSwitch        <= 1'b0;
      rsp_valid         <= 1'b0;
      rsp_err           <= 1'b0;
      if (take) begin
        rr_ptr            <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
        op_q              <= sel_op;
        control           <= sel_control;
        value             <= sel_value;
        rsp_id            <= grant_idx;
        LightLED          <= (sel_op == IO_OP_LED);
        LightSevenSegment <= (sel_op == IO_OP_SEG);
        ReadSwitch        <= read_ok(sel_op, sel_value);
        rsp_valid         <= sel_bad;
        rsp_err           <= sel_bad;
      end else if (state == ISSUE) begin
        rsp_valid <= read_ok(op_q, value);
      end
    end
  end

  // io updates SwitchValue on the same edge that enters RDWAIT, so it is passed through.
  assign rsp_data = (state == RDWAIT) & SwitchValue;

endmodule

// File: tb/tb_io_arbiter.sv
// tb/tb_io_arbiter.sv - timeline model and directed checks for io_arbiter
`timescale 1ns/1ps
module tb_io_arbiter;
  import io_pkg::*;

  localparam int N  = 2;
  localparam int IW = 1;
  localparam int T  = 1024;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [2*N-1:0]  req_op = '0;
  logic [32*N-1:0] req_control = '0;
  logic [32*N-1:0] req_value = '0;
  logic            rsp_valid, rsp_data, rsp_err;
  logic [IW-1:0]   rsp_id;
  logic            LightLED, LightSevenSegment, ReadSwitch;
  logic [31:0]     control, value;
  logic            SwitchValue = 1'b0;
  logic [13:0]     sw = 14'b10_0000_0000_1000;

  io_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_control(req_control), .req_value(req_value),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .LightLED(LightLED), .LightSevenSegment(LightSevenSegment), .ReadSwitch(ReadSwitch),
    .control(control), .value(value), .SwitchValue(SwitchValue)
  );

  always #5 clock = ~clock;

  // board io: registers the addressed toggle switch when asked
  always @(posedge clock) if (ReadSwitch) SwitchValue <= sw[value[3:0]];

  int          cyc = 0, m_ptr = 0, m_free = 0, m_win = -1, m_last = -1;
  logic [31:0] m_ctrl = '0, m_val = '0;
  bit          e_led[T], e_seg[T], e_rd[T], e_rv[T], e_err[T], e_dat[T];
  int          e_id[T];
  int          errors = 0, checks = 0;
  int          dut_grants[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    logic [N-1:0] er;
    int g;
    er    = '0;
    m_win = -1;
    if (reset_n && cyc >= m_free)
      for (int i = 0; i < N; i++) begin
        g = (m_ptr + i) % N;
        if (m_win < 0 && req_valid[g]) m_win = g;
      end
    if (m_win >= 0) er[m_win] = 1'b1;
    for (int i = 0; i < N; i++) if (req_ready[i]) dut_grants.push_back(i);
    chk("req_ready", 32'(req_ready), 32'(er));
    if (!reset_n) begin
      chk("rst_LightLED", 32'(LightLED), 0);
      chk("rst_LightSevenSegment", 32'(LightSevenSegment), 0);
      chk("rst_ReadSwitch", 32'(ReadSwitch), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_control", control, 0);
      chk("rst_value", value, 0);
    end else begin
      chk("LightLED", 32'(LightLED), 32'(e_led[cyc]));
      chk("LightSevenSegment", 32'(LightSevenSegment), 32'(e_seg[cyc]));
      chk("ReadSwitch", 32'(ReadSwitch), 32'(e_rd[cyc]));
      chk("control", control, m_ctrl);
      chk("value", value, m_val);
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv[cyc]));
      if (e_rv[cyc]) begin
        chk("rsp_id", 32'(rsp_id), 32'(e_id[cyc]));
        chk("rsp_data", 32'(rsp_data), 32'(e_dat[cyc]));
        chk("rsp_err", 32'(rsp_err), 32'(e_err[cyc]));
      end
    end
  endtask

  task automatic model_edge();
    int c, g;
    logic [1:0]  op;
    logic [31:0] ct, vl;
    c      = cyc;
    m_last = -1;
    if (!reset_n) begin
      for (int k = 1; k <= 3; k++) begin
        e_led[c+k] = 0; e_seg[c+k] = 0; e_rd[c+k] = 0; e_rv[c+k] = 0;
      end
      m_ptr = 0; m_free = c + 1; m_ctrl = '0; m_val = '0;
    end else if (m_win >= 0) begin
      g  = m_win;
      op = req_op[2*g +: 2];
      ct = req_control[32*g +: 32];
      vl = req_value[32*g +: 32];
      m_last = g; m_ptr = (g + 1) % N; m_ctrl = ct; m_val = vl;
      if (op == 2'd0) begin
        e_led[c+1] = 1; m_free = c + 2;
      end else if (op == 2'd1) begin
        e_seg[c+1] = 1; m_free = c + 2;
      end else if (op == 2'd2 && vl <= 32'd13) begin
        e_rd[c+1] = 1; e_rv[c+2] = 1; e_id[c+2] = g; e_err[c+2] = 0;
        e_dat[c+2] = sw[vl[3:0]]; m_free = c + 3;
      end else begin
        e_rv[c+1] = 1; e_id[c+1] = g; e_err[c+1] = 1; e_dat[c+1] = 0; m_free = c + 2;
      end
    end
    cyc = c + 1;
  endtask

  task automatic step();
    if (cyc > T - 5) begin
      $display("FAIL cycle_budget exceeded at cycle %0d", cyc);
      $fatal(1);
    end
    @(negedge clock);
    compare();
    @(posedge clock);
    model_edge();
    #2;
  endtask

  task automatic send(int r, logic [1:0] op, logic [31:0] ct, logic [31:0] vl);
    bit done;
    done = 0;
    req_op[2*r +: 2]       = op;
    req_control[32*r +: 32] = ct;
    req_value[32*r +: 32]   = vl;
    req_valid[r]            = 1'b1;
    for (int k = 0; k < 20 && !done; k++) begin
      step();
      if (m_last == r) done = 1;
    end
    req_valid[r] = 1'b0;
    chk("send_accepted", 32'(done), 1);
  endtask

  initial begin
    int cnt;
    repeat (3) step();
    chk("reset_LightLED", 32'(LightLED), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_control", control, 0);
    reset_n = 1'b1;
    repeat (3) step();
    chk("idle_ReadSwitch", 32'(ReadSwitch), 0);

    send(0, 2'd0, 32'd12, 32'd1);
    chk("led_strobe", 32'(LightLED), 1);
    chk("led_control", control, 32'd12);
    chk("led_value", value, 32'd1);
    chk("led_no_rsp", 32'(rsp_valid), 0);
    step();
    chk("led_strobe_off", 32'(LightLED), 0);

    send(1, 2'd1, 32'd2, 32'd7);
    chk("seg_strobe", 32'(LightSevenSegment), 1);
    chk("seg_value", value, 32'd7);
    step();

    send(1, 2'd2, 32'd0, 32'd3);
    chk("rd3_strobe", 32'(ReadSwitch), 1);
    chk("rd3_no_early_rsp", 32'(rsp_valid), 0);
    step();
    chk("rd3_rsp_valid", 32'(rsp_valid), 1);
    chk("rd3_rsp_id", 32'(rsp_id), 1);
    chk("rd3_rsp_data", 32'(rsp_data), 1);
    chk("rd3_rsp_err", 32'(rsp_err), 0);
    step();

    send(0, 2'd2, 32'd0, 32'd5);
    step();
    chk("rd5_rsp_data", 32'(rsp_data), 0);
    step();

    send(1, 2'd2, 32'd0, 32'd13);
    chk("rd13_strobe", 32'(ReadSwitch), 1);
    step();
    chk("rd13_rsp_data", 32'(rsp_data), 1);
    step();

    send(0, 2'd2, 32'd0, 32'd14);
    chk("rd14_no_strobe", 32'(ReadSwitch), 0);
    chk("rd14_rsp_valid", 32'(rsp_valid), 1);
    chk("rd14_rsp_err", 32'(rsp_err), 1);
    chk("rd14_rsp_data", 32'(rsp_data), 0);
    step();

    send(1, 2'd3, 32'd5, 32'd5);
    chk("rsvd_no_strobe", 32'(LightLED | LightSevenSegment | ReadSwitch), 0);
    chk("rsvd_rsp_err", 32'(rsp_err), 1);
    chk("rsvd_rsp_id", 32'(rsp_id), 1);
    step();

    dut_grants.delete();
    req_op      = '0;
    req_control = {32'd4, 32'd3};
    req_value   = {32'd1, 32'd0};
    req_valid   = 2'b11;
    cnt = 0;
    for (int k = 0; k < 60 && cnt < 8; k++) begin
      step();
      if (m_last >= 0) cnt++;
    end
    req_valid = '0;
    step();
    chk("rr_grant_count", 32'(dut_grants.size()), 8);
    for (int i = 0; i < 8; i++)
      chk("rr_order", (i < dut_grants.size()) ? 32'(dut_grants[i]) : 32'hff, 32'(i % 2));

    send(0, 2'd2, 32'd0, 32'd3);
    step();
    chk("pre_reset_rsp_valid", 32'(rsp_valid), 1);
    reset_n = 1'b0;
    #1;
    chk("mid_reset_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_reset_control", control, 0);
    chk("mid_reset_ready", 32'(req_ready), 0);
    step();
    step();
    reset_n = 1'b1;
    dut_grants.delete();
    req_valid = 2'b11;
    cnt = 0;
    for (int k = 0; k < 10 && cnt < 1; k++) begin
      step();
      if (m_last >= 0) cnt++;
    end
    req_valid = '0;
    chk("first_grant_after_reset", (dut_grants.size() > 0) ? 32'(dut_grants[0]) : 32'hff, 0);
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
